// File: rtl/bcd_serial_adder_if.sv
// Handshake and operand/result bundle for bcd_serial_adder.
// The master drives the request and operands; the slave returns status and the result.
interface bcd_serial_adder_if #(
  parameter int DIGITS = 4
);
  logic                  start;
  logic [4*DIGITS-1:0]   a;
  logic [4*DIGITS-1:0]   b;
  logic                  cin;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   sum;
  logic                  cout;
  logic                  err;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout, err
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout, err
  );
endinterface

// File: rtl/bcd_serial_adder.sv
// Digit-serial BCD adder: one decimal digit per clock, LSD first, with +6 correction.
// Define BCD_INVALID_CHECK_EN to build the non-BCD input digit flag; otherwise err is tied low.
module bcd_serial_adder #(
  parameter int DIGITS = 4
) (
  input logic               clk,
  input logic               rst_n,
  bcd_serial_adder_if.slave bus
);

  localparam int W  = 4 * DIGITS;
  localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(DIGITS - 1);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t          state;
  state_t          state_next;

  logic [W-1:0]    a_sh;
  logic [W-1:0]    b_sh;
  logic [W-1:0]    work;
  logic [W+3:0]    work_ext;
  logic            carry;
  logic [CW-1:0]   cnt;

  logic [W-1:0]    sum_q;
  logic            cout_q;
  logic            done_q;

  logic            load;
  logic            step;
  logic            finish;
  logic            busy_c;

  logic [4:0]      raw;
  logic [3:0]      digit;
  logic            carry_next;

  // Single shared digit adder; raw can reach 31 when non-BCD digits slip through.
  always_comb begin
    raw        = {1'b0, a_sh[3:0]} + {1'b0, b_sh[3:0]} + {4'b0000, carry};
    carry_next = 1'b0;
    digit      = raw[3:0];
    if (raw > 5'd9) begin
      digit      = raw[3:0] + 4'd6;
      carry_next = 1'b1;
    end
  end

  // New digit enters at the top so digit 0 ends up at the bottom after DIGITS steps.
  assign work_ext = {digit, work};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    step       = 1'b0;
    finish     = 1'b0;
    busy_c     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          load       = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        busy_c = 1'b1;
        step   = 1'b1;
        if (cnt == LAST_IDX) begin
          finish     = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      work   <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= finish;
      if (load) begin
        a_sh  <= bus.a;
        b_sh  <= bus.b;
        carry <= bus.cin;
        cnt   <= '0;
        work  <= '0;
      end else if (step) begin
        a_sh  <= a_sh >> 4;
        b_sh  <= b_sh >> 4;
        carry <= carry_next;
        cnt   <= cnt + CW'(1);
        work  <= work_ext[W+3:4];
      end
      if (finish) begin
        sum_q  <= work_ext[W+3:4];
        cout_q <= carry_next;
      end
    end
  end

`ifdef BCD_INVALID_CHECK_EN
  logic err_work;
  logic err_q;
  logic digit_bad;

  assign digit_bad = (a_sh[3:0] > 4'd9) || (b_sh[3:0] > 4'd9);

  // The working flag accumulates over the digits; the published flag only moves at completion.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_work <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      if (load) begin
        err_work <= 1'b0;
      end else if (step) begin
        err_work <= err_work | digit_bad;
      end
      if (finish) begin
        err_q <= err_work | digit_bad;
      end
    end
  end

  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

  assign bus.busy = busy_c;
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;

endmodule

// File: tb/tb_bcd_serial_adder.sv
// Randomized self-checking bench for bcd_serial_adder (DIGITS=4) against a decimal reference model.
// Honours BCD_INVALID_CHECK_EN when predicting err.
module tb_bcd_serial_adder;

  localparam int DIGITS = 4;

  logic clk;
  logic rst_n;

  int tests_run = 0;
  int tests_failed = 0;

  logic [15:0] exp_sum;
  logic        exp_cout;
  logic        exp_err;

  bcd_serial_adder_if #(.DIGITS(DIGITS)) bus ();

  bcd_serial_adder #(.DIGITS(DIGITS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Valid operands go through plain decimal arithmetic; non-BCD ones use the digit rule directly.
  function automatic void modelAdd(input logic [15:0] x, input logic [15:0] y, input logic c,
                                   output logic [15:0] s, output logic co, output logic e);
    bit valid = 1'b1;
    int dx = 0;
    int dy = 0;
    int total;
    int cc;
    int t;
    for (int i = 0; i < DIGITS; i++) begin
      if (x[4*i +: 4] > 4'd9 || y[4*i +: 4] > 4'd9) valid = 1'b0;
    end
    s = '0;
    if (valid) begin
      for (int i = DIGITS - 1; i >= 0; i--) begin
        dx = dx * 10 + int'(x[4*i +: 4]);
        dy = dy * 10 + int'(y[4*i +: 4]);
      end
      total = dx + dy + int'(c);
      co = (total >= 10000);
      total = total % 10000;
      for (int i = 0; i < DIGITS; i++) begin
        s[4*i +: 4] = 4'(total % 10);
        total = total / 10;
      end
    end else begin
      cc = int'(c);
      for (int i = 0; i < DIGITS; i++) begin
        t = int'(x[4*i +: 4]) + int'(y[4*i +: 4]) + cc;
        if (t > 9) begin
          s[4*i +: 4] = 4'(t + 6);
          cc = 1;
        end else begin
          s[4*i +: 4] = 4'(t);
          cc = 0;
        end
      end
      co = (cc != 0);
    end
`ifdef BCD_INVALID_CHECK_EN
    e = !valid;
`else
    e = 1'b0;
`endif
  endfunction

  function automatic logic [15:0] randOperand();
    logic [15:0] v = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if ($urandom_range(0, 7) == 0) v[4*i +: 4] = 4'($urandom_range(10, 15));
      else v[4*i +: 4] = 4'($urandom_range(0, 9));
    end
    return v;
  endfunction

  // Called at a negedge with busy low; returns at the negedge right after the start edge.
  task automatic applyStimulus(input logic [15:0] x, input logic [15:0] y, input logic c);
    bus.a     = x;
    bus.b     = y;
    bus.cin   = c;
    bus.start = 1'b1;
    modelAdd(x, y, c, exp_sum, exp_cout, exp_err);
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    bus.a     = 16'($urandom);
    bus.b     = 16'($urandom);
    bus.cin   = 1'($urandom);
  endtask

  // Returns at the negedge where done is high; poke injects ignored starts during RUN.
  task automatic waitDone(input string tag, input bit poke);
    int k = 0;
    int busy_cnt = 0;
    while (bus.done !== 1'b1 && k < 20) begin
      if (bus.busy === 1'b1) busy_cnt++;
      if (poke) begin
        if (k == 1 || k == 2) begin
          bus.start = 1'b1;
          bus.a     = 16'($urandom);
          bus.b     = 16'($urandom);
        end else begin
          bus.start = 1'b0;
        end
      end
      @(negedge clk);
      k++;
    end
    bus.start = 1'b0;
    checkOutput({tag, ".latency"}, 64'(k), 64'(DIGITS));
    checkOutput({tag, ".busy_cycles"}, 64'(busy_cnt), 64'(DIGITS));
    checkOutput({tag, ".busy_at_done"}, 64'(bus.busy), 64'(0));
    checkOutput({tag, ".sum"}, 64'(bus.sum), 64'(exp_sum));
    checkOutput({tag, ".cout"}, 64'(bus.cout), 64'(exp_cout));
    checkOutput({tag, ".err"}, 64'(bus.err), 64'(exp_err));
  endtask

  task automatic checkAfterDone(input string tag);
    @(negedge clk);
    checkOutput({tag, ".done_pulse"}, 64'(bus.done), 64'(0));
    checkOutput({tag, ".sum_hold"}, 64'(bus.sum), 64'(exp_sum));
  endtask

  initial begin
    bit saw_done;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.cin   = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset.busy", 64'(bus.busy), 64'(0));
    checkOutput("reset.done", 64'(bus.done), 64'(0));
    checkOutput("reset.sum", 64'(bus.sum), 64'(0));
    checkOutput("reset.cout", 64'(bus.cout), 64'(0));
    checkOutput("reset.err", 64'(bus.err), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);

    applyStimulus(16'h1234, 16'h5678, 1'b0);
    waitDone("basic", 1'b0);
    checkOutput("basic.const", 64'(bus.sum), 64'h6912);
    checkAfterDone("basic");

    applyStimulus(16'h9999, 16'h0001, 1'b0);
    waitDone("ripple_b", 1'b0);
    checkOutput("ripple_b.const", 64'({bus.cout, bus.sum}), 64'h10000);
    checkAfterDone("ripple_b");

    applyStimulus(16'h9999, 16'h0000, 1'b1);
    waitDone("ripple_cin", 1'b0);
    checkOutput("ripple_cin.const", 64'({bus.cout, bus.sum}), 64'h10000);
    checkAfterDone("ripple_cin");

    // Second start lands in the done cycle and must be accepted.
    applyStimulus(16'h5555, 16'h5555, 1'b0);
    waitDone("b2b_first", 1'b0);
    checkOutput("b2b_first.const", 64'({bus.cout, bus.sum}), 64'h11110);
    applyStimulus(16'h0000, 16'h0000, 1'b0);
    waitDone("b2b_second", 1'b0);
    checkAfterDone("b2b_second");

    applyStimulus(16'h1111, 16'h2222, 1'b0);
    waitDone("ignore_start", 1'b1);
    checkAfterDone("ignore_start");

    applyStimulus(16'h4321, 16'h1111, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checkOutput("abort.busy", 64'(bus.busy), 64'(0));
    checkOutput("abort.done", 64'(bus.done), 64'(0));
    checkOutput("abort.sum", 64'(bus.sum), 64'(0));
    checkOutput("abort.cout", 64'(bus.cout), 64'(0));
    checkOutput("abort.err", 64'(bus.err), 64'(0));
    saw_done = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (bus.done === 1'b1 || bus.busy === 1'b1) saw_done = 1'b1;
    end
    checkOutput("abort.no_done", 64'(saw_done), 64'(0));
    applyStimulus(16'h0808, 16'h0909, 1'b1);
    waitDone("after_abort", 1'b0);
    checkAfterDone("after_abort");

    applyStimulus(16'h00A0, 16'h0001, 1'b0);
    waitDone("invalid", 1'b0);
    checkAfterDone("invalid");
    applyStimulus(16'h0012, 16'h0034, 1'b0);
    waitDone("invalid_clear", 1'b0);
    checkAfterDone("invalid_clear");

    for (int n = 0; n < 40; n++) begin
      logic [15:0] ra;
      logic [15:0] rb;
      ra = randOperand();
      rb = randOperand();
      applyStimulus(ra, rb, 1'($urandom));
      waitDone($sformatf("rand%0d", n), 1'($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 1) == 0) checkAfterDone($sformatf("rand%0d", n));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/bcd_serial_adder.md
# bcd_serial_adder

Digit-serial multi-digit BCD adder: accepts two packed BCD operands on a start pulse and adds them one decimal digit per clock, least significant digit first, with decimal carry correction (+6). It is the addition counterpart to the team's 10's-complement BCD subtraction path. It sits behind a start/done handshake so wide decimal operands cost one 4-bit digit adder instead of DIGITS parallel adders.

## Interface
- DIGITS, 4: number of BCD digits per operand; legal range 1–16.
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous, active-low reset.
- start  input  1  request; sampled only when busy=0.
- a  input  4*DIGITS  augend, packed BCD, digit 0 in bits [3:0].
- b  input  4*DIGITS  addend, same packing.
- cin  input  1  decimal carry-in into digit 0.
- busy  output  1  high while a sum is in progress.
- done  output  1  one-cycle pulse when sum/cout are updated.
- sum  output  4*DIGITS  packed BCD result, held until the next completion.
- cout  output  1  decimal carry out of the top digit.
- err  output  1  non-BCD input digit flag (see Configuration); held with sum.

## Operation
- States: IDLE, RUN. Reset → IDLE.
- IDLE: start=1 at an edge latches a, b into shift registers, latches cin into the carry register, clears the digit counter, clears the working error bit, goes to RUN, busy=1.
- RUN: each edge processes digit i = counter: raw = a_i + b_i + carry (5 bits, 0..19). If raw > 9: digit = (raw + 6)[3:0], carry = 1; else digit = raw[3:0], carry = 0. Digit shifts into the working result from the top; operand registers shift right by 4; counter increments.
- After the digit with counter = DIGITS-1 is processed: sum ← working result, cout ← carry, err ← working error bit, done=1 for that one cycle, state → IDLE, busy=0.
- start while busy=1 is ignored (no queueing, no restart). a, b, cin may change freely after the start edge.
- Back-to-back: start may be asserted in the same cycle as done; it is accepted because busy=0 in that cycle.
- Non-BCD digits (>9) with the check disabled are added with the same rule; result is defined by the arithmetic above but is not meaningful BCD.
- Reset (rst_n=0 at an edge) in any state, including mid-RUN: aborts the operation, returns to IDLE; no done pulse is produced for the aborted operation.

## Timing
- Reset values: busy=0, done=0, sum=0, cout=0, err=0; internal counter, carry, and shift registers = 0.
- Latency: start sampled at edge N → done=1 and sum/cout/err valid in the cycle after edge N+DIGITS. busy=1 from after edge N through edge N+DIGITS.
- Throughput: one operation per DIGITS+1 cycles minimum with start held high.
- sum, cout, and err change only on the done edge (or reset); between operations they are stable.
- Critical path: one 4-bit add, compare against 9, and +6 correction per cycle.

## Configuration
- BCD_INVALID_CHECK_EN defined: during RUN, any a_i or b_i digit > 9 sets the working error bit; err is published with sum at done and is cleared only by the next completion or by reset.
- BCD_INVALID_CHECK_EN undefined: no check logic is built; err is tied to 0.

## Test plan
- DIGITS=4, a=0x1234, b=0x5678, cin=0, start → after 4 cycles done=1, sum=0x6912, cout=0, err=0.
- a=0x9999, b=0x0001, cin=0 → sum=0x0000, cout=1; repeat with a=0x9999, b=0x0000, cin=1 → sum=0x0000, cout=1.
- a=0x5555, b=0x5555, cin=0 → sum=0x1110, cout=1; then start asserted in the done cycle with a=0, b=0, cin=0 → accepted, next done gives sum=0x0000, cout=0.
- start pulsed at cycles 1 and 2 of RUN with different operands → ignored; single done with the original result; busy stays 1 for exactly 4 cycles.
- rst_n=0 for one edge after 2 digits of RUN → busy=0, sum=0, cout=0, no done; a fresh start afterwards completes normally.
- With BCD_INVALID_CHECK_EN: a=0x00A0, b=0x0001 → done with err=1; the next valid operation clears err to 0. Without the macro, err=0 for the same stimulus.
